// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dm_pkg
//  Purpose  : Shared memory-op encoding, constants and lane helpers for the
//             MEM stage and its data RAM.
//  Revision : 1.0  initial release
// ============================================================================
package dm_pkg;

    localparam int          MEM_OP_W    = 3;
    localparam logic [31:0] DM_BASE_DEF = 32'h0000_0000;
    localparam logic [31:0] RESET_PC    = 32'h0000_3000;

    typedef enum logic [MEM_OP_W-1:0] {
        MOP_WORD   = 3'd0,
        MOP_HALF_U = 3'd1,
        MOP_HALF_S = 3'd2,
        MOP_BYTE_U = 3'd3,
        MOP_BYTE_S = 3'd4
    } mem_op_e;

    // Unlisted codes fall into the default branches and behave as WORD.
    function automatic logic is_aligned(input logic [MEM_OP_W-1:0] op, input logic [1:0] a);
        case (op)
            MOP_HALF_U, MOP_HALF_S: return ~a[0];
            MOP_BYTE_U, MOP_BYTE_S: return 1'b1;
            default:                return (a == 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [MEM_OP_W-1:0] op, input logic [1:0] a);
        case (op)
            MOP_HALF_U, MOP_HALF_S: return a[1] ? 4'b1100 : 4'b0011;
            MOP_BYTE_U, MOP_BYTE_S: return 4'b0001 << a;
            default:                return 4'b1111;
        endcase
    endfunction

    // Replicating the low bits places them on every lane; byte enables pick one.
    function automatic logic [31:0] store_lane(input logic [MEM_OP_W-1:0] op, input logic [31:0] wd);
        case (op)
            MOP_HALF_U, MOP_HALF_S: return {2{wd[15:0]}};
            MOP_BYTE_U, MOP_BYTE_S: return {4{wd[7:0]}};
            default:                return wd;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [MEM_OP_W-1:0] op, input logic [1:0] a,
                                             input logic [31:0] word);
        logic [15:0] h;
        logic [7:0]  b;
        h = a[1] ? word[31:16] : word[15:0];
        b = word[{a, 3'b000} +: 8];
        case (op)
            MOP_HALF_U: return {16'h0000, h};
            MOP_HALF_S: return {{16{h[15]}}, h};
            MOP_BYTE_U: return {24'h000000, b};
            MOP_BYTE_S: return {{24{b[7]}}, b};
            default:    return word;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dm_ram.sv
`default_nettype none
// ============================================================================
//  Module   : dm_ram
//  Purpose  : Data word array with synchronous clear, byte-enable write port,
//             asynchronous read port and a simulation write log.
//  Revision : 1.0  initial release
// ============================================================================
module dm_ram
    import dm_pkg::*;
#(
    parameter int          DM_WORDS = 4096,
    parameter logic [31:0] DM_BASE  = DM_BASE_DEF,
    localparam int         IW       = $clog2(DM_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we_i,
    input  logic [IW-1:0] idx_i,
    input  logic [3:0]    be_i,
    input  logic [31:0]   wdata_i,
    input  logic [31:0]   pc_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DM_WORDS];
    logic [31:0] w_mask;
    logic [31:0] w_merged;

    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign w_mask[8*g +: 8] = {8{be_i[g]}};
    end

    assign rdata_o  = mem_q[idx_i];
    assign w_merged = (rdata_o & ~w_mask) | (wdata_i & w_mask);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[idx_i] <= w_merged;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && we_i) begin
            $display("%0t dm_ram: @%08h: *%08h <= %08h", $time, pc_i,
                     DM_BASE + {{(30-IW){1'b0}}, idx_i, 2'b00}, w_merged);
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/dm_stage.sv
`default_nettype none
// ============================================================================
//  Module   : dm_stage
//  Purpose  : MIPS memory-access stage: aligned loads/stores on a private data
//             RAM, results registered into the MEM/WB pipeline register.
//  Revision : 1.0  initial release
// ============================================================================
module dm_stage
    import dm_pkg::*;
#(
    parameter int          DM_WORDS = 4096,
    parameter logic [31:0] DM_BASE  = DM_BASE_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_ExMem,
    input  logic [31:0]         pc_ExMem,
    input  logic                memWrite_ExMem,
    input  logic                memRead_ExMem,
    input  logic [MEM_OP_W-1:0] memOp_ExMem,
    input  logic [31:0]         addr_ExMem,
    input  logic [31:0]         wdata_ExMem,
    input  logic                regWrite_ExMem,
    input  logic [4:0]          rd_ExMem,
    input  logic [31:0]         aluRes_ExMem,
    output logic [31:0]         pc_MemWb,
    output logic                regWrite_MemWb,
    output logic [4:0]          rd_MemWb,
    output logic                memToReg_MemWb,
    output logic [31:0]         aluRes_MemWb,
    output logic [31:0]         ldata_MemWb,
    output logic                alignErr_MemWb
);

    localparam int IW = $clog2(DM_WORDS);

    logic [IW-1:0] w_idx;
    logic          w_aligned;
    logic          w_store;
    logic          w_load;
    logic [31:0]   w_rdata;

    // Truncating the word offset gives the modulo-DM_WORDS wrap for free.
    assign w_idx     = IW'((addr_ExMem - DM_BASE) >> 2);
    assign w_aligned = is_aligned(memOp_ExMem, addr_ExMem[1:0]);
    assign w_store   = valid_ExMem & memWrite_ExMem & w_aligned & ~reset;
    assign w_load    = valid_ExMem & memRead_ExMem & ~memWrite_ExMem;

    dm_ram #(
        .DM_WORDS (DM_WORDS),
        .DM_BASE  (DM_BASE)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .we_i    (w_store),
        .idx_i   (w_idx),
        .be_i    (byte_en(memOp_ExMem, addr_ExMem[1:0])),
        .wdata_i (store_lane(memOp_ExMem, wdata_ExMem)),
        .pc_i    (pc_ExMem),
        .rdata_o (w_rdata)
    );

    logic [31:0] pc_d, pc_q;
    logic        regWrite_d, regWrite_q;
    logic [4:0]  rd_d, rd_q;
    logic        memToReg_d, memToReg_q;
    logic [31:0] aluRes_d, aluRes_q;
    logic [31:0] ldata_d, ldata_q;
    logic        alignErr_d, alignErr_q;

    always_comb begin
        pc_d       = pc_ExMem;
        rd_d       = rd_ExMem;
        aluRes_d   = aluRes_ExMem;
        regWrite_d = valid_ExMem & regWrite_ExMem;
        memToReg_d = w_load;
        ldata_d    = '0;
        if (w_load && w_aligned) begin
            ldata_d = load_ext(memOp_ExMem, addr_ExMem[1:0], w_rdata);
        end
        alignErr_d = valid_ExMem & (memRead_ExMem | memWrite_ExMem) & ~w_aligned;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            regWrite_q <= 1'b0;
            rd_q       <= '0;
            memToReg_q <= 1'b0;
            aluRes_q   <= '0;
            ldata_q    <= '0;
            alignErr_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            regWrite_q <= regWrite_d;
            rd_q       <= rd_d;
            memToReg_q <= memToReg_d;
            aluRes_q   <= aluRes_d;
            ldata_q    <= ldata_d;
            alignErr_q <= alignErr_d;
        end
    end

    assign pc_MemWb       = pc_q;
    assign regWrite_MemWb = regWrite_q;
    assign rd_MemWb       = rd_q;
    assign memToReg_MemWb = memToReg_q;
    assign aluRes_MemWb   = aluRes_q;
    assign ldata_MemWb    = ldata_q;
    assign alignErr_MemWb = alignErr_q;

endmodule
`default_nettype wire

// File: tb/tb_dm_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dm_stage
//  Purpose  : Randomized scoreboard bench for dm_stage against a byte-array
//             reference memory.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dm_stage;

    localparam int MEM_BYTES = 4096 * 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_ExMem;
    logic [31:0] pc_ExMem;
    logic        memWrite_ExMem;
    logic        memRead_ExMem;
    logic [2:0]  memOp_ExMem;
    logic [31:0] addr_ExMem;
    logic [31:0] wdata_ExMem;
    logic        regWrite_ExMem;
    logic [4:0]  rd_ExMem;
    logic [31:0] aluRes_ExMem;
    logic [31:0] pc_MemWb;
    logic        regWrite_MemWb;
    logic [4:0]  rd_MemWb;
    logic        memToReg_MemWb;
    logic [31:0] aluRes_MemWb;
    logic [31:0] ldata_MemWb;
    logic        alignErr_MemWb;

    dm_stage dut (
        .clk            (clk),
        .reset          (reset),
        .valid_ExMem    (valid_ExMem),
        .pc_ExMem       (pc_ExMem),
        .memWrite_ExMem (memWrite_ExMem),
        .memRead_ExMem  (memRead_ExMem),
        .memOp_ExMem    (memOp_ExMem),
        .addr_ExMem     (addr_ExMem),
        .wdata_ExMem    (wdata_ExMem),
        .regWrite_ExMem (regWrite_ExMem),
        .rd_ExMem       (rd_ExMem),
        .aluRes_ExMem   (aluRes_ExMem),
        .pc_MemWb       (pc_MemWb),
        .regWrite_MemWb (regWrite_MemWb),
        .rd_MemWb       (rd_MemWb),
        .memToReg_MemWb (memToReg_MemWb),
        .aluRes_MemWb   (aluRes_MemWb),
        .ldata_MemWb    (ldata_MemWb),
        .alignErr_MemWb (alignErr_MemWb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        rw;
        logic [4:0]  rd;
        logic        m2r;
        logic [31:0] alu;
        logic [31:0] ld;
        logic        ae;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] ref_mem [MEM_BYTES];
    int         checks = 0;
    int         errors = 0;
    logic       done   = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %08h expected %08h", name, $time, got, exp);
        end
    endtask

    // Monitor: the MEM/WB register presents one result per clock.
    initial begin
        exp_t e;
        while (!done) begin
            @(posedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("pc",       pc_MemWb,              e.pc);
                chk("regWrite", 32'(regWrite_MemWb),   32'(e.rw));
                chk("rd",       32'(rd_MemWb),         32'(e.rd));
                chk("memToReg", 32'(memToReg_MemWb),   32'(e.m2r));
                chk("aluRes",   aluRes_MemWb,          e.alu);
                chk("ldata",    ldata_MemWb,           e.ld);
                chk("alignErr", 32'(alignErr_MemWb),   32'(e.ae));
            end
        end
    end

    // Reference model: byte-addressed memory, access size from the op code.
    task automatic issue(input logic rst, input logic v, input logic mw, input logic mr,
                         input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input logic rw, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] pc);
        exp_t        e;
        int          size;
        bit          sgn;
        bit          mis;
        int          base;
        logic [31:0] val;
        reset = rst; valid_ExMem = v; memWrite_ExMem = mw; memRead_ExMem = mr;
        memOp_ExMem = op; addr_ExMem = a; wdata_ExMem = wd; regWrite_ExMem = rw;
        rd_ExMem = rd; aluRes_ExMem = alu; pc_ExMem = pc;

        size = (op == 3'd1 || op == 3'd2) ? 2 : (op == 3'd3 || op == 3'd4) ? 1 : 4;
        sgn  = (op == 3'd2 || op == 3'd4);
        mis  = (a % size) != 0;
        base = int'(a % MEM_BYTES);
        if (rst) begin
            for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;
            e = '{pc: 32'h0000_3000, rw: 1'b0, rd: 5'd0, m2r: 1'b0, alu: 32'h0, ld: 32'h0, ae: 1'b0};
        end else begin
            val = 32'h0;
            if (v && mr && !mw && !mis) begin
                for (int i = 0; i < size; i++) val = val | (32'(ref_mem[base + i]) << (8 * i));
                if (sgn && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8 * size));
            end
            if (v && mw && !mis) begin
                for (int i = 0; i < size; i++) ref_mem[base + i] = 8'(wd >> (8 * i));
            end
            e = '{pc: pc, rw: v & rw, rd: rd, m2r: v & mr & ~mw, alu: alu, ld: val,
                  ae: v & (mr | mw) & mis};
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic op_st(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
        issue(1'b0, 1'b1, 1'b1, 1'b0, op, a, wd, 1'b0, 5'd0, a, 32'h0000_3100 + a);
    endtask

    task automatic op_ld(input logic [2:0] op, input logic [31:0] a, input logic [4:0] rd);
        issue(1'b0, 1'b1, 1'b0, 1'b1, op, a, 32'h0, 1'b1, rd, a, 32'h0000_3200 + a);
    endtask

    initial begin
        logic        rst, v, mw, mr, rw;
        logic [2:0]  op;
        logic [31:0] a, up;
        int          kind;

        // Store during reset must be discarded.
        issue(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 32'h20, 32'hDEAD_BEEF, 1'b1, 5'd3, 32'h55, 32'h100);
        op_ld(3'd0, 32'h10, 5'd1);
        op_ld(3'd0, 32'h20, 5'd2);
        op_st(3'd0, 32'h20, 32'h1234_5678);
        op_ld(3'd0, 32'h20, 5'd4);
        op_st(3'd3, 32'h21, 32'h0000_00AB);
        op_ld(3'd4, 32'h21, 5'd5);
        op_ld(3'd3, 32'h21, 5'd6);
        op_ld(3'd0, 32'h20, 5'd7);
        op_st(3'd1, 32'h22, 32'hFFFF_8001);
        op_ld(3'd2, 32'h22, 5'd8);
        op_ld(3'd1, 32'h22, 5'd9);
        op_st(3'd0, 32'h25, 32'hCAFE_F00D);
        op_ld(3'd2, 32'h23, 5'd10);
        op_ld(3'd0, 32'h20, 5'd11);
        issue(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h20, 32'h0, 1'b1, 5'd12, 32'h77, 32'h3300);
        op_ld(3'd0, 32'h20, 5'd13);
        issue(1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 32'h24, 32'hA5A5_5A5A, 1'b1, 5'd14, 32'h24, 32'h3304);
        op_ld(3'd0, 32'h24, 5'd15);
        op_ld(3'd7, 32'h4020, 5'd16);

        for (int n = 0; n < 600; n++) begin
            rst  = ($urandom_range(0, 79) == 0);
            v    = ($urandom_range(0, 7) != 0);
            kind = $urandom_range(0, 9);
            mw   = (kind <= 3) || (kind == 8);
            mr   = (kind >= 4 && kind <= 8);
            rw   = $urandom_range(0, 1) == 1;
            op   = 3'($urandom_range(0, 7));
            up   = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
            a    = (up & ~32'h3F) | 32'($urandom_range(0, 63));
            issue(rst, v, mw, mr, op, a, $urandom, rw, 5'($urandom), $urandom, $urandom);
        end

        issue(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #3;
        chk("scoreboard_drain", 32'(sb_q.size()), 32'h0);
        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
